// File: rtl/grn_attractor_scheduler_pkg.sv
// Shared types for the GRN attractor scheduler: FSM state encoding, default
// widths and the result record handed to the consumer.
package grn_attractor_scheduler_pkg;

  localparam int GRN_N_NODES = 8;
  localparam int GRN_STEP_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STEP   = 3'd2,
    S_CHECK  = 3'd3,
    S_REPORT = 3'd4,
    S_NEXT   = 3'd5,
    S_FIN    = 3'd6
  } grn_sched_state_t;

  typedef struct packed {
    logic [GRN_N_NODES-1:0] init;
    logic [GRN_STEP_W-1:0]  steps;
    logic                   timeout;
  } grn_result_t;

endpackage

// File: rtl/grn_attractor_scheduler_result_reg.sv
// Single-entry valid/ready holding register for one sweep result.
// Handshake: data_o is stable while valid_o=1; the entry retires on valid_o&ready_i.
module grn_result_reg
  import grn_attractor_scheduler_pkg::*;
#(
  parameter type T = grn_result_t
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  T     data_i,
  input  logic ready_i,
  output logic valid_o,
  output T     data_o
);

  logic valid_q;
  T     data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/grn_attractor_scheduler.sv
// Sweeps initial states over a tortoise/hare node array, stepping each until
// s0 meets s1 or the step budget runs out, and streams out one result per state.
module grn_attractor_scheduler
  import grn_attractor_scheduler_pkg::*;
#(
  parameter int N_NODES   = GRN_N_NODES,
  parameter int STEP_W    = GRN_STEP_W,
  parameter int MAX_STEPS = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_NODES-1:0]     state_begin,
  input  logic [N_NODES-1:0]     state_end,
  output logic                   busy,
  output logic                   done,
  output logic                   reset_nos,
  output logic                   start_s0,
  output logic                   start_s1,
  output logic [N_NODES-1:0]     init_state,
  input  logic [N_NODES-1:0]     s0_vec,
  input  logic [N_NODES-1:0]     s1_vec,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N_NODES-1:0]     res_init_state,
  output logic [STEP_W-1:0]      res_steps,
  output logic                   res_timeout,
  output grn_sched_state_t       dbg_state
);

  typedef struct packed {
    logic [N_NODES-1:0] init;
    logic [STEP_W-1:0]  steps;
    logic               timeout;
  } result_t;

  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);

  grn_sched_state_t   state_q, state_d;
  logic [N_NODES-1:0] cur_q, cur_d;
  logic [N_NODES-1:0] end_q, end_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic               busy_q, done_q, reset_nos_q, start_s0_q, start_s1_q;
  logic               res_load;
  logic               meet;
  result_t            res_in, res_out;

  // The match right after step 1 is guaranteed (both copies advanced once) and is not a meet.
  assign meet = (s0_vec == s1_vec) && (step_cnt_q >= STEP_W'(2));

  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    end_d           = end_q;
    step_cnt_d      = step_cnt_q;
    res_load        = 1'b0;
    res_in.init     = cur_q;
    res_in.steps    = step_cnt_q;
    res_in.timeout  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        cur_d   = state_begin;
        end_d   = state_end;
        state_d = (state_begin > state_end) ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        step_cnt_d = '0;
        state_d    = S_STEP;
      end
      S_STEP: begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (meet) begin
          res_load = 1'b1;
          state_d  = S_REPORT;
        end else if (step_cnt_q == MAX_CNT) begin
          res_load       = 1'b1;
          res_in.timeout = 1'b1;
          state_d        = S_REPORT;
        end else begin
          state_d = S_STEP;
        end
      end
      S_REPORT: if (res_valid && res_ready) state_d = S_NEXT;
      S_NEXT: begin
        if (cur_q == end_q) begin
          state_d = S_FIN;
        end else begin
          cur_d   = cur_q + N_NODES'(1);
          state_d = S_LOAD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so they line up with the state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      step_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      step_cnt_q  <= step_cnt_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_FIN);
      done_q      <= (state_d == S_FIN);
      reset_nos_q <= (state_d == S_LOAD);
      start_s0_q  <= (state_d == S_STEP);
      start_s1_q  <= (state_d == S_STEP);
    end
  end

  grn_result_reg #(.T(result_t)) u_result_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (res_load),
    .data_i  (res_in),
    .ready_i (res_ready),
    .valid_o (res_valid),
    .data_o  (res_out)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign reset_nos      = reset_nos_q;
  assign start_s0       = start_s0_q;
  assign start_s1       = start_s1_q;
  assign init_state     = cur_q;
  assign res_init_state = res_out.init;
  assign res_steps      = res_out.steps;
  assign res_timeout    = res_out.timeout;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_grn_attractor_scheduler.sv
// Directed bench for grn_attractor_scheduler with a behavioural tortoise/hare
// node-array model (identity or increment-mod-16 network).
module tb_grn_attractor_scheduler;
  import grn_attractor_scheduler_pkg::*;

  localparam int N  = 8;
  localparam int SW = 16;
  localparam int RW = N + SW + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     state_begin = '0;
  logic [N-1:0]     state_end = '0;
  logic             busy, done, reset_nos, start_s0, start_s1;
  logic [N-1:0]     init_state;
  logic [N-1:0]     s0_vec, s1_vec;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [N-1:0]     res_init_state;
  logic [SW-1:0]    res_steps;
  logic             res_timeout;
  grn_sched_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  grn_attractor_scheduler #(.N_NODES(N), .STEP_W(SW), .MAX_STEPS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .state_begin(state_begin), .state_end(state_end),
    .busy(busy), .done(done),
    .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
    .init_state(init_state), .s0_vec(s0_vec), .s1_vec(s1_vec),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_init_state(res_init_state), .res_steps(res_steps),
    .res_timeout(res_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // node-array model: s1 advances every step, s0 on the first of each pair
  logic         net_inc = 1'b0;
  logic [N-1:0] m_s0 = '0;
  logic [N-1:0] m_s1 = '0;
  logic         m_pass = 1'b0;

  function automatic logic [N-1:0] net_f(input logic [N-1:0] x, input logic inc);
    return inc ? ((x + 8'd1) & 8'h0F) : x;
  endfunction

  always @(posedge clk) begin
    if (reset_nos) begin
      m_s0   <= init_state;
      m_s1   <= init_state;
      m_pass <= 1'b0;
    end else begin
      if (start_s1) m_s1 <= net_f(m_s1, net_inc);
      if (start_s0) begin
        if (!m_pass) m_s0 <= net_f(m_s0, net_inc);
        m_pass <= ~m_pass;
      end
    end
  end
  assign s0_vec = m_s0;
  assign s1_vec = m_s1;

  // monitor: collects accepted results and counts done/valid cycles
  logic [RW-1:0] got_q[$];
  int done_cnt  = 0;
  int valid_cnt = 0;
  always @(negedge clk) begin
    if (res_valid && res_ready) got_q.push_back({res_init_state, res_steps, res_timeout});
    if (done) done_cnt++;
    if (res_valid) valid_cnt++;
  end

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int got_rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input logic [N-1:0] init, input logic [SW-1:0] steps, input logic to);
    exp_q.push_back({init, steps, to});
  endtask

  task automatic drain_scoreboard(input string tag);
    logic [RW-1:0] e;
    check({tag, "_count"}, got_q.size() - got_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        check({tag, "_result"}, 32'(got_q[got_rd]), 32'(e));
        got_rd++;
      end
    end
    got_rd = got_q.size();
  endtask

  // driver tasks
  task automatic do_start(input logic [N-1:0] b, input logic [N-1:0] e);
    @(posedge clk); #1;
    state_begin = b;
    state_end   = e;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    int d0;
    d0 = done_cnt;
    cycles = 0;
    while (done_cnt == d0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  initial begin
    int n, d0, v0;
    // reset state
    #23;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_strobes", {29'd0, reset_nos, start_s0, start_s1}, 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_fields", 32'({res_init_state, res_steps, res_timeout}), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // identity network, range 0..3
    net_inc = 1'b0;
    d0 = done_cnt;
    do_start(8'd0, 8'd3);
    @(negedge clk);
    check("id_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) expect_result(N'(i), 16'd2, 1'b0);
    wait_done("id", 200, n);
    @(negedge clk);
    check("id_busy_after", 32'(busy), 0);
    check("id_done_once", 32'(done_cnt - d0), 1);
    drain_scoreboard("id");

    // increment network, budget exhausted
    net_inc = 1'b1;
    do_start(8'd5, 8'd5);
    expect_result(8'd5, 16'd4, 1'b1);
    wait_done("inc", 200, n);
    drain_scoreboard("inc");

    // back-pressure on the result stream
    net_inc = 1'b0;
    res_ready = 1'b0;
    do_start(8'd2, 8'd3);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", 32'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(res_valid), 1);
      check("bp_fields", 32'({res_init_state, res_steps, res_timeout}), 32'({8'd2, 16'd2, 1'b0}));
      check("bp_no_strobe", {29'd0, reset_nos, start_s0, start_s1}, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    expect_result(8'd2, 16'd2, 1'b0);
    expect_result(8'd3, 16'd2, 1'b0);
    wait_done("bp", 200, n);
    drain_scoreboard("bp");

    // empty range
    v0 = valid_cnt;
    d0 = done_cnt;
    do_start(8'd7, 8'd3);
    wait_done("empty", 2, n);
    @(negedge clk);
    check("empty_no_valid", 32'(valid_cnt - v0), 0);
    check("empty_busy", 32'(busy), 0);
    check("empty_done_once", 32'(done_cnt - d0), 1);
    drain_scoreboard("empty");

    // start re-pulsed mid-sweep is ignored
    d0 = done_cnt;
    do_start(8'd0, 8'd1);
    repeat (2) @(posedge clk);
    do_start(8'd9, 8'd12);
    expect_result(8'd0, 16'd2, 1'b0);
    expect_result(8'd1, 16'd2, 1'b0);
    wait_done("repulse", 200, n);
    repeat (3) @(negedge clk);
    check("repulse_done_once", 32'(done_cnt - d0), 1);
    check("repulse_idle", 32'(dbg_state), 32'(S_IDLE));
    drain_scoreboard("repulse");

    // asynchronous reset in the middle of a step
    do_start(8'd4, 8'd6);
    n = 0;
    while (!start_s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("arst_in_step", 32'(dbg_state), 32'(S_STEP));
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_strobes", {29'd0, reset_nos, start_s0, start_s1}, 0);
    check("arst_state", 32'(dbg_state), 32'(S_IDLE));
    check("arst_init", 32'(init_state), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 4; i <= 6; i++) expect_result(N'(i), 16'd2, 1'b0);
    do_start(8'd4, 8'd6);
    wait_done("arst_rerun", 300, n);
    drain_scoreboard("arst_rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
